// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - state encodings, parameter limits and output patterns for pipeline_ctrl
package pipeline_ctrl_pkg;

  localparam logic [1:0] CTRL_RUN  = 2'd0;
  localparam logic [1:0] CTRL_LOAD = 2'd1;
  localparam logic [1:0] CTRL_MEMW = 2'd2;

  localparam int LOAD_BUBBLES_MIN = 1;
  localparam int LOAD_BUBBLES_MAX = 15;
  localparam int MEM_TIMEOUT_MIN  = 1;
  localparam int MEM_TIMEOUT_MAX  = 255;

  typedef enum logic [1:0] {
    ST_RUN  = CTRL_RUN,
    ST_LOAD = CTRL_LOAD,
    ST_MEMW = CTRL_MEMW
  } ctrl_state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_flush;
  } ctrl_out_t;

  // Flush overrides enable, so the load bubble keeps id_ex_en high and relies on id_ex_flush.
  localparam ctrl_out_t PAT_RUN    = ctrl_out_t'(8'b11111_000);
  localparam ctrl_out_t PAT_BRANCH = ctrl_out_t'(8'b11111_110);
  localparam ctrl_out_t PAT_LOAD   = ctrl_out_t'(8'b00111_010);
  localparam ctrl_out_t PAT_FREEZE = ctrl_out_t'(8'b00000_001);

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// rtl/pipeline_ctrl_sat_counter.sv - saturating up-counter with asynchronous clear
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush scheduler merging load-use, branch and DRAM wait
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int LOAD_BUBBLES = 1,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_hazard,
  input  logic        is_branch,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mem_wb_flush,
  output logic        mem_timeout,
  output logic [1:0]  ctrl_state,
  output logic [31:0] stall_cycles
);

  localparam int NB = clamp(LOAD_BUBBLES, LOAD_BUBBLES_MIN, LOAD_BUBBLES_MAX);
  localparam int NT = clamp(MEM_TIMEOUT, MEM_TIMEOUT_MIN, MEM_TIMEOUT_MAX);
  localparam logic [3:0] BUBBLE_INIT = 4'(NB - 1);
  localparam logic [7:0] WAIT_LIMIT  = 8'(NT);

  ctrl_state_e state, state_next, ret, ret_next;
  logic [3:0]  bub, bub_next;
  logic [7:0]  wcnt, wcnt_next;
  ctrl_out_t   pat;
  logic        wait_req;

  assign wait_req = mem_req & ~mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      ret   <= ST_RUN;
      bub   <= '0;
      wcnt  <= '0;
    end else begin
      state <= state_next;
      ret   <= ret_next;
      bub   <= bub_next;
      wcnt  <= wcnt_next;
    end
  end

  always_comb begin
    state_next  = state;
    ret_next    = ret;
    bub_next    = bub;
    wcnt_next   = wcnt;
    pat         = PAT_RUN;
    mem_timeout = 1'b0;
    case (state)
      ST_RUN: begin
        if (wait_req) begin
          pat        = PAT_FREEZE;
          ret_next   = ST_RUN;
          wcnt_next  = '0;
          state_next = ST_MEMW;
        end else if (load_hazard) begin
          pat = PAT_LOAD;
          if (NB > 1) begin
            bub_next   = BUBBLE_INIT;
            state_next = ST_LOAD;
          end
        end else if (is_branch) begin
          pat = PAT_BRANCH;
        end
      end
      ST_LOAD: begin
        // A preempting wait leaves bub untouched so the remaining bubbles resume after release.
        if (wait_req) begin
          pat        = PAT_FREEZE;
          ret_next   = ST_LOAD;
          wcnt_next  = '0;
          state_next = ST_MEMW;
        end else begin
          pat      = PAT_LOAD;
          bub_next = bub - 4'd1;
          if (bub == 4'd1) state_next = ST_RUN;
        end
      end
      ST_MEMW: begin
        wcnt_next = wcnt + 8'd1;
        if (mem_ack || (wcnt_next == WAIT_LIMIT)) begin
          mem_timeout = ~mem_ack;
          if (ret == ST_LOAD) begin
            pat        = PAT_LOAD;
            bub_next   = bub - 4'd1;
            state_next = (bub == 4'd1) ? ST_RUN : ST_LOAD;
          end else begin
            pat        = PAT_RUN;
            state_next = ST_RUN;
          end
        end else begin
          pat = PAT_FREEZE;
        end
      end
      default: begin
        state_next = ST_RUN;
        ret_next   = ST_RUN;
      end
    endcase
  end

  assign pc_en        = pat.pc_en;
  assign if_id_en     = pat.if_id_en;
  assign id_ex_en     = pat.id_ex_en;
  assign ex_mem_en    = pat.ex_mem_en;
  assign mem_wb_en    = pat.mem_wb_en;
  assign if_id_flush  = pat.if_id_flush;
  assign id_ex_flush  = pat.id_ex_flush;
  assign mem_wb_flush = pat.mem_wb_flush;
  assign ctrl_state   = state;

  sat_counter #(.WIDTH(32)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~pc_en),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed and random checks of pipeline_ctrl against a stall-debt model
module tb_pipeline_ctrl;

  // Output vector order: {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_wb_flush}
  localparam logic [7:0] E_RUN    = 8'b11111_000;
  localparam logic [7:0] E_BRANCH = 8'b11111_110;
  localparam logic [7:0] E_LOAD   = 8'b00111_010;
  localparam logic [7:0] E_FREEZE = 8'b00000_001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_hazard = 1'b0, is_branch = 1'b0, mem_req = 1'b0, mem_ack = 1'b0;

  logic pc_en_a, if_id_en_a, id_ex_en_a, ex_mem_en_a, mem_wb_en_a;
  logic if_id_flush_a, id_ex_flush_a, mem_wb_flush_a, tmo_a;
  logic [1:0] state_a;
  logic [31:0] stall_a;
  logic pc_en_b, if_id_en_b, id_ex_en_b, ex_mem_en_b, mem_wb_en_b;
  logic if_id_flush_b, id_ex_flush_b, mem_wb_flush_b, tmo_b;
  logic [1:0] state_b;
  logic [31:0] stall_b;
  logic [7:0] outs_a, outs_b;

  int checks = 0;
  int errors = 0;

  // Abstract model: bubble cycles still owed, whether a DRAM wait is open, and its age.
  int     nb[2] = '{3, 4};
  int     to[2] = '{5, 15};
  int     owed[2];
  bit     waiting[2];
  int     waited[2];
  longint stalls[2];

  always #5 clk = ~clk;

  pipeline_ctrl #(.LOAD_BUBBLES(3), .MEM_TIMEOUT(5)) u_a (
    .clk(clk), .rst_n(rst_n), .load_hazard(load_hazard), .is_branch(is_branch),
    .mem_req(mem_req), .mem_ack(mem_ack), .pc_en(pc_en_a), .if_id_en(if_id_en_a),
    .id_ex_en(id_ex_en_a), .ex_mem_en(ex_mem_en_a), .mem_wb_en(mem_wb_en_a),
    .if_id_flush(if_id_flush_a), .id_ex_flush(id_ex_flush_a), .mem_wb_flush(mem_wb_flush_a),
    .mem_timeout(tmo_a), .ctrl_state(state_a), .stall_cycles(stall_a)
  );

  pipeline_ctrl #(.LOAD_BUBBLES(4), .MEM_TIMEOUT(15)) u_b (
    .clk(clk), .rst_n(rst_n), .load_hazard(load_hazard), .is_branch(is_branch),
    .mem_req(mem_req), .mem_ack(mem_ack), .pc_en(pc_en_b), .if_id_en(if_id_en_b),
    .id_ex_en(id_ex_en_b), .ex_mem_en(ex_mem_en_b), .mem_wb_en(mem_wb_en_b),
    .if_id_flush(if_id_flush_b), .id_ex_flush(id_ex_flush_b), .mem_wb_flush(mem_wb_flush_b),
    .mem_timeout(tmo_b), .ctrl_state(state_b), .stall_cycles(stall_b)
  );

  assign outs_a = {pc_en_a, if_id_en_a, id_ex_en_a, ex_mem_en_a, mem_wb_en_a,
                   if_id_flush_a, id_ex_flush_a, mem_wb_flush_a};
  assign outs_b = {pc_en_b, if_id_en_b, id_ex_en_b, ex_mem_en_b, mem_wb_en_b,
                   if_id_flush_b, id_ex_flush_b, mem_wb_flush_b};

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      owed[k] = 0; waiting[k] = 1'b0; waited[k] = 0; stalls[k] = 0;
    end
  endfunction

  function automatic void model_step(input int k, input bit h, input bit b, input bit r, input bit a,
                                     output logic [7:0] o, output bit t);
    t = 1'b0;
    if (waiting[k]) begin
      waited[k]++;
      if (a || waited[k] == to[k]) begin
        t = !a;
        waiting[k] = 1'b0;
        if (owed[k] > 0) begin o = E_LOAD; owed[k]--; end
        else o = E_RUN;
      end else begin
        o = E_FREEZE;
      end
    end else if (r && !a) begin
      o = E_FREEZE; waiting[k] = 1'b1; waited[k] = 0;
    end else if (owed[k] > 0) begin
      o = E_LOAD; owed[k]--;
    end else if (h) begin
      o = E_LOAD; owed[k] = nb[k] - 1;
    end else if (b) begin
      o = E_BRANCH;
    end else begin
      o = E_RUN;
    end
    if (!o[7]) stalls[k]++;
  endfunction

  task automatic cycle(input bit h, input bit b, input bit r, input bit a);
    logic [7:0] eo;
    bit et;
    int es;
    @(negedge clk);
    load_hazard = h; is_branch = b; mem_req = r; mem_ack = a;
    #1;
    for (int k = 0; k < 2; k++) begin
      es = waiting[k] ? 2 : ((owed[k] > 0) ? 1 : 0);
      chk("ctrl_state", k, {30'd0, (k == 0) ? state_a : state_b}, es);
      chk("stall_cycles", k, (k == 0) ? stall_a : stall_b, 32'(stalls[k]));
      model_step(k, h, b, r, a, eo, et);
      chk("pattern", k, {24'd0, (k == 0) ? outs_a : outs_b}, {24'd0, eo});
      chk("mem_timeout", k, {31'd0, (k == 0) ? tmo_a : tmo_b}, {31'd0, et});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    load_hazard = 0; is_branch = 0; mem_req = 0; mem_ack = 0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int first_tmo;
    model_reset();
    do_reset();

    // Idle after reset: all enables high, no flushes
    cycle(0, 0, 0, 0);
    chk("reset_idle_a", 0, {24'd0, outs_a}, {24'd0, E_RUN});
    cycle(0, 0, 0, 0);

    // Single-cycle load-use hazard: 3 bubbles on u_a, 4 on u_b
    cycle(1, 0, 0, 0);
    repeat (5) cycle(0, 0, 0, 0);
    chk("load_stall_total", 0, stall_a, 32'd3);
    chk("load_stall_total", 1, stall_b, 32'd4);

    // Load and branch together: branch ignored, stall taken
    do_reset();
    cycle(1, 1, 0, 0);
    chk("load_branch_if_id_flush", 0, {31'd0, if_id_flush_a}, 32'd0);
    cycle(0, 0, 0, 0);
    chk("load_branch_state", 0, {30'd0, state_a}, 32'd1);
    repeat (4) cycle(0, 0, 0, 0);

    // Memory wait acked after 4 cycles
    do_reset();
    repeat (4) cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 1);
    chk("memwait_release", 0, {24'd0, outs_a}, {24'd0, E_RUN});
    cycle(0, 0, 0, 0);
    chk("memwait_stalls", 0, stall_a, 32'd4);
    chk("memwait_state", 1, {30'd0, state_b}, 32'd0);

    // Never-acked request: u_a times out on its 5th wait cycle
    do_reset();
    first_tmo = -1;
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 1, 0);
      if (tmo_a && first_tmo < 0) first_tmo = i;
    end
    chk("timeout_cycle", 0, first_tmo, 32'd5);
    repeat (3) cycle(0, 0, 0, 0);

    // Load stall preempted on its 2nd cycle, ack 2 cycles later
    do_reset();
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 1);
    repeat (5) cycle(0, 0, 0, 0);
    chk("preempt_total", 1, stall_b, 32'd6);

    // Asynchronous reset mid-wait
    do_reset();
    repeat (3) cycle(0, 0, 1, 0);
    @(negedge clk);
    load_hazard = 0; is_branch = 0; mem_req = 0; mem_ack = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_state", 0, {30'd0, state_a}, 32'd0);
    chk("async_rst_state", 1, {30'd0, state_b}, 32'd0);
    chk("async_rst_pattern", 0, {24'd0, outs_a}, {24'd0, E_RUN});
    chk("async_rst_pattern", 1, {24'd0, outs_b}, {24'd0, E_RUN});
    chk("async_rst_stalls", 0, stall_a, 32'd0);
    chk("async_rst_stalls", 1, stall_b, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 5) == 0, ($urandom % 5) == 0, ($urandom % 4) == 0, ($urandom % 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
